// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: row strobe, column debounce, one-deep code handoff with overflow flag.
// Define KEY_SCAN_HISTORY_EN to keep the previous digit in O_key_num[7:4].
module key_scan #(
  parameter int C_SCAN_NUM     = 100000,
  parameter int C_DEBOUNCE_NUM = 1000000
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic [3:0] I_col,
  output logic [3:0] O_row,
  output logic       O_key_valid,
  input  logic       I_key_ack,
  output logic [3:0] O_key_code,
  output logic [7:0] O_key_num,
  output logic       O_key_ovf
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam logic [32:0] SCAN_LIM = 33'(C_SCAN_NUM);
  localparam logic [32:0] DEB_LIM  = 33'(C_DEBOUNCE_NUM);

  state_t      state;
  logic [3:0]  col_m, col_s, pat;
  logic [1:0]  r;
  logic [32:0] cnt, cnt_inc;
  logic        single;
  logic        ack_take;
`ifdef KEY_SCAN_HISTORY_EN
  logic [3:0]  hist;
`endif

  function automatic logic [1:0] zpos(input logic [3:0] v);
    case (v)
      4'b1101: zpos = 2'd1;
      4'b1011: zpos = 2'd2;
      4'b0111: zpos = 2'd3;
      default: zpos = 2'd0;
    endcase
  endfunction

  always_comb begin
    single = (col_s == 4'b1110) || (col_s == 4'b1101) ||
             (col_s == 4'b1011) || (col_s == 4'b0111);
  end

  assign cnt_inc  = (cnt == {33{1'b1}}) ? cnt : cnt + 33'd1;
  assign ack_take = I_key_ack && O_key_valid;
  assign O_row    = ~(4'b0001 << r);

`ifdef KEY_SCAN_HISTORY_EN
  assign O_key_num = {hist, O_key_code};
`else
  assign O_key_num = {4'h0, O_key_code};
`endif

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      col_m       <= 4'hF;
      col_s       <= 4'hF;
      state       <= SCAN;
      pat         <= 4'hF;
      r           <= 2'd0;
      cnt         <= '0;
      O_key_valid <= 1'b0;
      O_key_code  <= 4'h0;
      O_key_ovf   <= 1'b0;
`ifdef KEY_SCAN_HISTORY_EN
      hist        <= 4'h0;
`endif
    end else begin
      col_m <= I_col;
      col_s <= col_m;
      case (state)
        SCAN: begin
          if (cnt >= SCAN_LIM) begin
            cnt <= '0;
            if (single) begin
              pat   <= col_s;
              state <= DEBOUNCE;
            end else begin
              r <= r + 2'd1;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        DEBOUNCE: begin
          if (col_s != pat) begin
            r     <= r + 2'd1;
            cnt   <= '0;
            state <= SCAN;
          end else if (cnt >= DEB_LIM) begin
            state <= PRESSED;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PRESSED: begin
          cnt   <= '0;
          state <= RELEASE;
        end
        default: begin
          // row stays parked on the pressed key until all columns read idle
          if (col_s != 4'hF) begin
            cnt <= '0;
          end else if (cnt_inc >= DEB_LIM) begin
            cnt   <= '0;
            r     <= 2'd0;
            state <= SCAN;
          end else begin
            cnt <= cnt_inc;
          end
        end
      endcase

      // a fresh press always wins over a coincident ack
      if (state == PRESSED) begin
        O_key_code  <= {r, zpos(pat)};
        O_key_valid <= 1'b1;
        if (O_key_valid && !I_key_ack) O_key_ovf <= 1'b1;
`ifdef KEY_SCAN_HISTORY_EN
        hist <= O_key_code;
`endif
      end else if (ack_take) begin
        O_key_valid <= 1'b0;
        O_key_ovf   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with a keypad model (keys[r][c] = 1 means pressed).
module tb_key_scan;
  logic       I_clk = 1'b0;
  logic       I_rst_n = 1'b0;
  logic [3:0] I_col;
  logic [3:0] O_row;
  logic       O_key_valid;
  logic       I_key_ack = 1'b0;
  logic [3:0] O_key_code;
  logic [7:0] O_key_num;
  logic       O_key_ovf;

  logic [3:0] keys [4];
  int n_chk = 0;
  int n_pass = 0;

  key_scan #(.C_SCAN_NUM(4), .C_DEBOUNCE_NUM(8)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_col(I_col), .O_row(O_row),
    .O_key_valid(O_key_valid), .I_key_ack(I_key_ack), .O_key_code(O_key_code),
    .O_key_num(O_key_num), .O_key_ovf(O_key_ovf)
  );

  always #5 I_clk = ~I_clk;

  always_comb begin
    I_col = 4'hF;
    for (int i = 0; i < 4; i++)
      if (!O_row[i]) I_col = I_col & ~keys[i];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic release_all();
    for (int i = 0; i < 4; i++) keys[i] = 4'h0;
  endtask

  task automatic wait_valid(input string tag);
    int i = 0;
    while (!O_key_valid && i < 200) begin @(negedge I_clk); i++; end
    chk(tag, O_key_valid, 1);
  endtask

  task automatic wait_row(input string tag, input logic [3:0] target);
    int i = 0;
    while (O_row == target && i < 100) begin @(negedge I_clk); i++; end
    while (O_row != target && i < 100) begin @(negedge I_clk); i++; end
    chk(tag, O_row, target);
  endtask

  task automatic ack();
    I_key_ack = 1'b1;
    @(negedge I_clk);
    I_key_ack = 1'b0;
  endtask

  initial begin
    int i;
    release_all();
    #1;
    chk("rst_row", O_row, 4'b1110);
    chk("rst_valid", O_key_valid, 0);
    chk("rst_code", O_key_code, 0);
    chk("rst_num", O_key_num, 0);
    chk("rst_ovf", O_key_ovf, 0);
    repeat (2) @(negedge I_clk);
    I_rst_n = 1'b1;
    repeat (3) @(negedge I_clk);

    // row 2, col 1 held -> code 9, single valid
    keys[2] = 4'b0010;
    wait_valid("k9_valid");
    chk("k9_code", O_key_code, 4'h9);
    chk("k9_num", O_key_num, 8'h09);
    chk("k9_row", O_row, 4'b1011);
    ack();
    chk("k9_ack", O_key_valid, 0);
    repeat (60) @(negedge I_clk);
    chk("k9_hold_novalid", O_key_valid, 0);
    chk("k9_hold_row", O_row, 4'b1011);
    release_all();
    repeat (20) @(negedge I_clk);

    // 5-cycle glitch on row 0 col 0
    wait_row("gl_row0", 4'b1110);
    repeat (2) @(negedge I_clk);
    keys[0] = 4'b0001;
    repeat (5) @(negedge I_clk);
    release_all();
    wait_row("gl_next_row", 4'b1101);
    repeat (100) @(negedge I_clk);
    chk("gl_novalid", O_key_valid, 0);

    // two columns low on row 1 -> ignored
    keys[1] = 4'b0110;
    repeat (100) @(negedge I_clk);
    chk("two_col_novalid", O_key_valid, 0);
    release_all();
    repeat (5) @(negedge I_clk);

    // 0x3 then 0xA, each acked
    keys[0] = 4'b1000;
    wait_valid("k3_valid");
    chk("k3_code", O_key_code, 4'h3);
    ack();
    release_all();
    repeat (20) @(negedge I_clk);
    keys[2] = 4'b0100;
    wait_valid("kA_valid");
    chk("kA_code", O_key_code, 4'hA);
`ifdef KEY_SCAN_HISTORY_EN
    chk("kA_num", O_key_num, 8'h3A);
`else
    chk("kA_num", O_key_num, 8'h0A);
`endif
    ack();
    chk("kA_ack", O_key_valid, 0);
    release_all();
    repeat (20) @(negedge I_clk);

    // overwrite: 0x5 then 0xF with no ack between
    keys[1] = 4'b0010;
    wait_valid("k5_valid");
    chk("k5_code", O_key_code, 4'h5);
    chk("k5_ovf", O_key_ovf, 0);
    release_all();
    repeat (20) @(negedge I_clk);
    keys[3] = 4'b1000;
    i = 0;
    while (O_key_code != 4'hF && i < 200) begin @(negedge I_clk); i++; end
    chk("ovf_code", O_key_code, 4'hF);
    chk("ovf_flag", O_key_ovf, 1);
    chk("ovf_valid", O_key_valid, 1);
    ack();
    chk("ovf_ack_valid", O_key_valid, 0);
    chk("ovf_ack_flag", O_key_ovf, 0);
    release_all();
    repeat (20) @(negedge I_clk);

    // async reset mid-debounce
    wait_row("md_row0", 4'b1110);
    repeat (2) @(negedge I_clk);
    keys[0] = 4'b0001;
    repeat (6) @(negedge I_clk);
    #2 I_rst_n = 1'b0;
    #1;
    chk("md_row", O_row, 4'b1110);
    chk("md_valid", O_key_valid, 0);
    chk("md_code", O_key_code, 0);
    chk("md_num", O_key_num, 0);
    @(negedge I_clk);
    I_rst_n = 1'b1;

    // key held through reset is a new press
    wait_valid("held_valid");
    chk("held_code", O_key_code, 4'h0);

    // async reset with a code pending
    #2 I_rst_n = 1'b0;
    #1;
    chk("pend_valid", O_key_valid, 0);
    chk("pend_ovf", O_key_ovf, 0);
    chk("pend_row", O_row, 4'b1110);
    release_all();
    @(negedge I_clk);
    I_rst_n = 1'b1;
    repeat (5) @(negedge I_clk);
    chk("post_valid", O_key_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 The block SHALL have parameter C_SCAN_NUM, default 100000, giving the clock cycles each row is driven before its columns are sampled.
REQ-002 The block SHALL have parameter C_DEBOUNCE_NUM, default 1000000, giving the consecutive stable cycles required for both press and release.
REQ-003 The block SHALL have port I_clk, input, 1 bit: system clock.
REQ-004 The block SHALL have port I_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port I_col, input, 4 bits: keypad column lines, active-low, externally pulled up, asynchronous to I_clk.
REQ-006 The block SHALL have port O_row, output, 4 bits: keypad row drive, one-hot active-low.
REQ-007 The block SHALL have port O_key_valid, output, 1 bit: a new key code is pending.
REQ-008 The block SHALL have port I_key_ack, input, 1 bit: the consumer accepts the pending code.
REQ-009 The block SHALL have port O_key_code, output, 4 bits: code of the most recent debounced key.
REQ-010 The block SHALL have port O_key_num, output, 8 bits: digit history, directly displayable as two hex digits.
REQ-011 The block SHALL have port O_key_ovf, output, 1 bit: sticky flag, a key was overwritten while still pending.

Function
REQ-012 I_col SHALL pass through a two-flop synchronizer; all logic SHALL use only the synchronized value (col_s).
REQ-013 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-014 In SCAN, row index r (0..3) SHALL drive O_row with bit r low for C_SCAN_NUM+1 cycles, then col_s is sampled.
REQ-015 On that sample, col_s with exactly one zero bit SHALL latch the pattern, hold r, clear the counter and enter DEBOUNCE; any other value SHALL advance r modulo 4 (3 wraps to 0).
REQ-016 In DEBOUNCE, col_s differing from the latched pattern SHALL return to SCAN with r advanced and the counter cleared.
REQ-017 In DEBOUNCE, the counter reaching C_DEBOUNCE_NUM SHALL enter PRESSED.
REQ-018 PRESSED SHALL last one cycle: O_key_code = {r[1:0], c[1:0]}, where c is the zero-bit position; O_key_num updates per REQ-029; O_key_valid = 1; then go to RELEASE.
REQ-019 In RELEASE, O_row SHALL stay on row r; the counter SHALL clear whenever col_s != 4'hF.
REQ-020 In RELEASE, C_DEBOUNCE_NUM consecutive col_s == 4'hF cycles SHALL return to SCAN at r = 0.
REQ-021 O_key_valid SHALL clear in the cycle after a rising clock edge that samples I_key_ack = 1 while O_key_valid = 1; I_key_ack SHALL be ignored while O_key_valid = 0.
REQ-022 If PRESSED occurs while O_key_valid = 1 and no ack is sampled in that cycle, the code SHALL be overwritten, O_key_valid SHALL stay 1, and O_key_ovf SHALL set.
REQ-023 If PRESSED and an ack coincide, the new code SHALL win: O_key_valid = 1 and O_key_ovf unchanged.
REQ-024 O_key_ovf SHALL clear on the next accepted ack that does not coincide with PRESSED.
REQ-025 Counters SHALL be 33 bits wide and saturate, never wrap.
REQ-026 O_key_valid SHALL rise no sooner than 2 + C_DEBOUNCE_NUM + 1 cycles after a clean press becomes sampled.

Reset
REQ-027 Asserting I_rst_n low SHALL, asynchronously and at any point, including mid-debounce or with a code pending, force: state SCAN, r = 0, O_row = 4'b1110, counters 0, synchronizer 4'hF, O_key_valid = 0, O_key_code = 0, O_key_num = 0, O_key_ovf = 0.
REQ-028 Keys held through reset release SHALL be detected as new presses.

Configuration
REQ-029 With macro KEY_SCAN_HISTORY_EN defined, PRESSED SHALL shift O_key_num <= {O_key_num[3:0], new code}.
REQ-030 Without KEY_SCAN_HISTORY_EN, PRESSED SHALL set O_key_num <= {4'h0, new code}, and no history register SHALL exist.

Verification (C_SCAN_NUM=4, C_DEBOUNCE_NUM=8)
REQ-031 Row 2, col 1 held (I_col=4'b1101 when O_row=4'b1011) -> one O_key_valid, O_key_code=4'h9, no further valid until release plus 8 stable cycles.
REQ-032 Press a 5-cycle glitch (shorter than debounce) -> no O_key_valid; scan resumes on the next row.
REQ-033 Keys 0x3 then 0xA, acked each time, with history enabled -> O_key_num=8'h3A; with history disabled -> O_key_num=8'h0A.
REQ-034 Two keys pressed with no ack between them -> O_key_code = second key, O_key_ovf=1; an ack clears O_key_valid and O_key_ovf.
REQ-035 I_col=4'b1001 (two columns low) -> ignored, no O_key_valid.
REQ-036 I_rst_n pulsed low mid-DEBOUNCE and with a code pending -> all outputs return to reset values immediately, without waiting for a clock edge.
